jhash_pack: RTL and testbench
=============================

// Module: jhash_pack
// PURPOSE
//  Parametrised input packer for the jhash engine. Pulls IN_LANES x 32-bit beats from a
//  first-word-fall-through source FIFO and repacks them into 3-word (96-bit) groups for
//  the mix stage. Handles partial final beats and flushes the tail group with a word
//  count. Tracks the total message length for the hash initial value.
//  Sits between the source FIFO and the jhash mix/final core.
// PARAMETERS
//  IN_LANES  2   32-bit words per input beat (1..4)
//  LEN_W     32  width of the stream_len word counter
// PORTS
//  clk          in   1                 clock
//  rst          in   1                 reset: asynchronous, active-high
//  ce           in   1                 enable; low returns the block to IDLE and clears it
//  src_empty    in   1                 source FIFO empty
//  src_data     in   IN_LANES*32       FWFT beat; lane 0 = bits [31:0] = oldest word
//  src_last     in   1                 current beat is the final beat of the message
//  src_nlanes   in   $clog2(IN_LANES+1) valid lanes on the final beat (0..IN_LANES)
//  src_getn     out  1                 active-low pop strobe
//  stream_ack   in   1                 consumer accepts the presented group
//  stream_data0 out  32                group word 0 (oldest)
//  stream_data1 out  32                group word 1
//  stream_data2 out  32                group word 2
//  stream_valid out  1                 group presented
//  stream_done  out  1                 presented group is the final group
//  stream_left  out  2                 valid words in the presented group (0..3)
//  stream_len   out  LEN_W             total words accepted this message
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, src_getn=1, stream_valid=0, stream_done=0, stream_left=0,
//   stream_data*=0, stream_len=0. Reset mid-message discards buffer contents immediately.
//  Buffer: word FIFO of depth BUF=IN_LANES+2 words; cnt = number of occupied words (0..BUF).
//  Group fire: fire = stream_valid & stream_ack; removes min(cnt,3) words.
//  Pop: src_getn=0 when state=RUN & ce & ~src_empty & (cnt - fire*3 + n) <= BUF,
//   where n = src_last ? src_nlanes : IN_LANES. Pop and fire may coincide in one cycle.
//   Popped words are appended in lane order; stream_len += n (wraps mod 2^LEN_W).
//  Non-final beats always carry IN_LANES words; src_nlanes is ignored on them.
//  Output is registered-buffer driven: data/left/done stay stable while valid & ~ack.
//  States:
//   IDLE  -> RUN when ce. stream_len cleared on entry to RUN.
//   RUN   : valid = cnt>=3, left=3, done=0. Pop of a src_last beat -> FLUSH.
//   FLUSH : no pops. valid=1. done = (cnt<=3). left = done ? cnt : 3.
//           Unused words zero-filled. Final fire -> DONE.
//   DONE  : valid=0; stream_len held. Leaves only via ce=0 (-> IDLE).
//  ce=0 in any state -> IDLE next cycle, cnt=0; src_getn=1 combinationally while ce=0.
//  Empty message (src_last with src_nlanes=0 and cnt=0): one group, left=0, done=1, data=0.
//  Message length that is an exact multiple of 3: the last full group carries done=1, left=3.
//  src_empty mid-message: stall with no pop; groups already formed keep presenting.
//  stream_ack without stream_valid is ignored.
// STRUCTURE
//  jhash_pkg: DW=32, GROUP=3, state encodings (IDLE/RUN/FLUSH/DONE), count width function.
//  Sub-module jhash_pack_buf: BUF-word shift buffer with variable-width append
//   (0..IN_LANES words) and 3-word pop from the head; exposes cnt and head 3 words.
//  jhash_pack top: FSM, pop/fire arithmetic, stream_len counter, output muxing.
// TESTING
//  IN_LANES=2, 4 full beats, then last beat with nlanes=2 (10 words) -> groups
//   (w0..2),(w3..5),(w6..8) left=3 done=0, then (w9,0,0) left=1 done=1; stream_len=10.
//  IN_LANES=2, 3 beats with last nlanes=2 (6 words) -> two groups; the second has done=1
//   left=3; no extra empty group.
//  src_last with nlanes=0 at cnt=0 -> single group, data=0, left=0, done=1; stream_len=0.
//  stream_ack held low 20 cycles with buffer full -> src_getn stays 1, data stable;
//   ack high -> one pop and one fire in the same cycle.
//  Random src_empty/ack gaps, IN_LANES in {1,3,4}, 1..40 words -> word order and count
//   match the scoreboard; exactly one done group per message.
//  rst asserted mid-FLUSH, or ce dropped mid-RUN -> outputs at reset values next edge;
//   the next message packs from word 0.

Source files
------------

// File: rtl/jhash_pkg.sv
// rtl/jhash_pkg.sv - shared constants, FSM encoding and width helper for the jhash packer
//
// Purpose: common definitions imported by jhash_pack and jhash_pack_buf.
//   DW       data word width
//   GROUP    words per mix-stage group
//   state_t  packer FSM encoding
//   cnt_w()  bits needed to hold a count of 0..n
package jhash_pkg;

   localparam int DW    = 32;
   localparam int GROUP = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/jhash_pack_buf.sv
// rtl/jhash_pack_buf.sv - word shift buffer with variable append and 3-word head pop
//
// Purpose: holds up to IN_LANES+2 words in arrival order. Each cycle it may drop
//   min(cnt,3) words from the head and append 0..IN_LANES words behind the survivors.
//   Slots above cnt are always zero, so the head words come out zero-filled.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   clr         synchronous clear of all contents
//   pop         remove min(cnt,3) words from the head
//   push        append push_n words from push_data (lane 0 first)
//   push_n      number of words to append
//   push_data   IN_LANES packed words
//   cnt         occupied words
//   head0..2    oldest three slots
module jhash_pack_buf
   import jhash_pkg::*;
#(
   parameter int IN_LANES = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              clr,
   input  logic                              pop,
   input  logic                              push,
   input  logic [$clog2(IN_LANES+1)-1:0]     push_n,
   input  logic [IN_LANES*DW-1:0]            push_data,
   output logic [cnt_w(IN_LANES+2)-1:0]      cnt,
   output logic [DW-1:0]                     head0,
   output logic [DW-1:0]                     head1,
   output logic [DW-1:0]                     head2
);

   localparam int BUF = IN_LANES + 2;
   localparam int CW  = cnt_w(BUF);

   logic [DW-1:0] mem     [BUF];
   logic [DW-1:0] mem_nxt [BUF];
   logic [CW-1:0] cnt_nxt;

   // Surviving words shift down by popn; new lanes land right behind them.
   always_comb begin
      int popn;
      int keep;
      int addn;
      popn = 0;
      if (pop) popn = (int'(cnt) < GROUP) ? int'(cnt) : GROUP;
      keep = int'(cnt) - popn;
      addn = push ? int'(push_n) : 0;
      for (int i = 0; i < BUF; i++) begin
         mem_nxt[i] = '0;
         for (int j = 0; j < BUF; j++)
            if (i < keep && j == i + popn) mem_nxt[i] = mem[j];
         for (int l = 0; l < IN_LANES; l++)
            if (l < addn && i == keep + l) mem_nxt[i] = push_data[l*DW +: DW];
      end
      cnt_nxt = CW'(keep + addn);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         for (int i = 0; i < BUF; i++) mem[i] <= '0;
      end else if (clr) begin
         cnt <= '0;
         for (int i = 0; i < BUF; i++) mem[i] <= '0;
      end else begin
         cnt <= cnt_nxt;
         for (int i = 0; i < BUF; i++) mem[i] <= mem_nxt[i];
      end
   end

   assign head0 = mem[0];
   assign head1 = mem[1];
   assign head2 = mem[2];

endmodule

// File: rtl/jhash_pack.sv
// rtl/jhash_pack.sv - repacks IN_LANES-word FWFT beats into 3-word groups for jhash
//
// Purpose: pops beats from a first-word-fall-through FIFO, regroups the words into
//   3-word groups, flushes a zero-filled tail group with a word count and tracks the
//   message length.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   ce                            enable; low clears the block back to IDLE
//   src_empty/src_data/src_last   FWFT source beat, lane 0 = oldest word
//   src_nlanes                    valid lanes on the final beat
//   src_getn                      active-low pop strobe
//   stream_ack                    consumer accepts the presented group
//   stream_data0..2               group words, 0 = oldest
//   stream_valid/done/left        group presented / final group / valid words
//   stream_len                    words accepted this message
module jhash_pack
   import jhash_pkg::*;
#(
   parameter int IN_LANES = 2,
   parameter int LEN_W    = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          ce,
   input  logic                          src_empty,
   input  logic [IN_LANES*DW-1:0]        src_data,
   input  logic                          src_last,
   input  logic [$clog2(IN_LANES+1)-1:0] src_nlanes,
   output logic                          src_getn,
   input  logic                          stream_ack,
   output logic [DW-1:0]                 stream_data0,
   output logic [DW-1:0]                 stream_data1,
   output logic [DW-1:0]                 stream_data2,
   output logic                          stream_valid,
   output logic                          stream_done,
   output logic [1:0]                    stream_left,
   output logic [LEN_W-1:0]              stream_len
);

   localparam int BUF = IN_LANES + 2;
   localparam int CW  = cnt_w(BUF);
   localparam int NW  = $clog2(IN_LANES + 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic [NW-1:0] n;
   logic          pop;
   logic          fire;
   logic [DW-1:0] h0, h1, h2;

   jhash_pack_buf #(.IN_LANES(IN_LANES)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .clr       (~ce),
      .pop       (fire),
      .push      (pop),
      .push_n    (n),
      .push_data (src_data),
      .cnt       (cnt),
      .head0     (h0),
      .head1     (h1),
      .head2     (h2)
   );

   // Output decode straight from the registered state and buffer contents, so the
   // presented group cannot change while it waits for an ack.
   always_comb begin
      n            = src_last ? src_nlanes : NW'(IN_LANES);
      stream_valid = 1'b0;
      stream_done  = 1'b0;
      stream_left  = 2'd0;
      case (state)
         ST_RUN: begin
            if (int'(cnt) >= GROUP) begin
               stream_valid = 1'b1;
               stream_left  = 2'd3;
            end
         end
         ST_FLUSH: begin
            stream_valid = 1'b1;
            stream_done  = (int'(cnt) <= GROUP);
            stream_left  = stream_done ? 2'(cnt) : 2'd3;
         end
         default: ;
      endcase
      stream_data0 = stream_valid ? h0 : '0;
      stream_data1 = stream_valid ? h1 : '0;
      stream_data2 = stream_valid ? h2 : '0;
      fire         = stream_valid & stream_ack;
      // Space check counts the words the same-cycle fire frees up.
      pop = (state == ST_RUN) && ce && !src_empty &&
            ((int'(cnt) - (fire ? GROUP : 0) + int'(n)) <= BUF);
      src_getn = ~pop;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         stream_len <= '0;
      end else if (!ce) begin
         state      <= ST_IDLE;
         stream_len <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               state      <= ST_RUN;
               stream_len <= '0;
            end
            ST_RUN: begin
               if (pop) begin
                  stream_len <= stream_len + LEN_W'(n);
                  if (src_last) state <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               if (fire && stream_done) state <= ST_DONE;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_jhash_pack.sv
// tb/tb_jhash_pack.sv - scoreboard bench for jhash_pack over IN_LANES 1..4
module tb_jhash_pack;

   typedef struct {
      logic [127:0] data;
      bit           last;
      int           nl;
   } beat_t;

   typedef struct {
      logic [31:0] d0, d1, d2;
      logic [1:0]  left;
      bit          done;
   } exp_t;

   logic         clk, rst, ce;
   logic         src_empty, src_last, stream_ack;
   logic [127:0] src_data;
   logic [2:0]   src_nlanes;
   logic [1:0]   si;

   logic [3:0]   getn_v, valid_v, done_v, ce_v;
   logic [1:0]   left_v [4];
   logic [31:0]  d0_v [4], d1_v [4], d2_v [4], len_v [4];

   logic         m_getn, m_valid, m_done;
   logic [1:0]   m_left;
   logic [31:0]  m_d0, m_d1, m_d2, m_len;

   beat_t beat_q[$];
   exp_t  exp_q[$];
   exp_t  mon_e;
   exp_t  hold_e;

   int total = 0, bad = 0;
   int pop_cnt = 0, done_pops = 0, done_seen = 0, msg_id = 0;
   bit gap_en = 0, ack_force = 1, ack_val = 0;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   assign ce_v[0] = ce && (si == 2'd0);
   assign ce_v[1] = ce && (si == 2'd1);
   assign ce_v[2] = ce && (si == 2'd2);
   assign ce_v[3] = ce && (si == 2'd3);

   assign m_getn  = getn_v[si];
   assign m_valid = valid_v[si];
   assign m_done  = done_v[si];
   assign m_left  = left_v[si];
   assign m_d0    = d0_v[si];
   assign m_d1    = d1_v[si];
   assign m_d2    = d2_v[si];
   assign m_len   = len_v[si];

   jhash_pack #(.IN_LANES(1), .LEN_W(32)) u_l1 (
      .clk(clk), .rst(rst), .ce(ce_v[0]), .src_empty(src_empty),
      .src_data(src_data[31:0]), .src_last(src_last), .src_nlanes(src_nlanes[0:0]),
      .src_getn(getn_v[0]), .stream_ack(stream_ack),
      .stream_data0(d0_v[0]), .stream_data1(d1_v[0]), .stream_data2(d2_v[0]),
      .stream_valid(valid_v[0]), .stream_done(done_v[0]), .stream_left(left_v[0]),
      .stream_len(len_v[0]));

   jhash_pack #(.IN_LANES(2), .LEN_W(32)) u_l2 (
      .clk(clk), .rst(rst), .ce(ce_v[1]), .src_empty(src_empty),
      .src_data(src_data[63:0]), .src_last(src_last), .src_nlanes(src_nlanes[1:0]),
      .src_getn(getn_v[1]), .stream_ack(stream_ack),
      .stream_data0(d0_v[1]), .stream_data1(d1_v[1]), .stream_data2(d2_v[1]),
      .stream_valid(valid_v[1]), .stream_done(done_v[1]), .stream_left(left_v[1]),
      .stream_len(len_v[1]));

   jhash_pack #(.IN_LANES(3), .LEN_W(32)) u_l3 (
      .clk(clk), .rst(rst), .ce(ce_v[2]), .src_empty(src_empty),
      .src_data(src_data[95:0]), .src_last(src_last), .src_nlanes(src_nlanes[1:0]),
      .src_getn(getn_v[2]), .stream_ack(stream_ack),
      .stream_data0(d0_v[2]), .stream_data1(d1_v[2]), .stream_data2(d2_v[2]),
      .stream_valid(valid_v[2]), .stream_done(done_v[2]), .stream_left(left_v[2]),
      .stream_len(len_v[2]));

   jhash_pack #(.IN_LANES(4), .LEN_W(32)) u_l4 (
      .clk(clk), .rst(rst), .ce(ce_v[3]), .src_empty(src_empty),
      .src_data(src_data), .src_last(src_last), .src_nlanes(src_nlanes),
      .src_getn(getn_v[3]), .stream_ack(stream_ack),
      .stream_data0(d0_v[3]), .stream_data1(d1_v[3]), .stream_data2(d2_v[3]),
      .stream_valid(valid_v[3]), .stream_done(done_v[3]), .stream_left(left_v[3]),
      .stream_len(len_v[3]));

   // Source FIFO and consumer model: retire popped beats, present the head beat.
   initial begin
      src_empty  = 1;
      src_data   = '0;
      src_last   = 0;
      src_nlanes = '0;
      stream_ack = 0;
      forever begin
         @(posedge clk);
         #1;
         while (done_pops < pop_cnt && beat_q.size() > 0) begin
            beat_q.delete(0);
            done_pops++;
         end
         if (beat_q.size() > 0 && !(gap_en && $urandom_range(0, 2) == 0)) begin
            src_empty  = 0;
            src_data   = beat_q[0].data;
            src_last   = beat_q[0].last;
            src_nlanes = 3'(beat_q[0].nl);
         end else begin
            src_empty = 1;
            src_last  = 0;
         end
         stream_ack = ack_force ? ack_val : ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: every accepted group is checked against the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         if (!m_getn) pop_cnt++;
         if (m_valid && stream_ack) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL extra_group: got %h %h %h left=%0d done=%0b, required none",
                        m_d0, m_d1, m_d2, m_left, m_done);
            end else begin
               mon_e = exp_q.pop_front();
               if (m_d0 !== mon_e.d0 || m_d1 !== mon_e.d1 || m_d2 !== mon_e.d2 ||
                   m_left !== mon_e.left || m_done !== mon_e.done) begin
                  bad++;
                  $display("FAIL group: got %h %h %h left=%0d done=%0b, required %h %h %h left=%0d done=%0b",
                           m_d0, m_d1, m_d2, m_left, m_done,
                           mon_e.d0, mon_e.d1, mon_e.d2, mon_e.left, mon_e.done);
               end
            end
            if (m_done) done_seen++;
         end
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Queue a message of n words as source beats plus its expected groups.
   task automatic send_msg(input int n);
      logic [31:0] w[$];
      beat_t       b;
      exp_t        e;
      int          lanes, i, k, g;
      lanes = int'(si) + 1;
      msg_id++;
      for (int x = 0; x < n; x++) w.push_back(32'((msg_id << 16) | (x + 1)));
      g = (n == 0) ? 1 : (n + 2) / 3;
      for (int j = 0; j < g; j++) begin
         e.d0   = (3*j   < n) ? w[3*j]   : 32'h0;
         e.d1   = (3*j+1 < n) ? w[3*j+1] : 32'h0;
         e.d2   = (3*j+2 < n) ? w[3*j+2] : 32'h0;
         e.done = (j == g - 1);
         e.left = e.done ? 2'(n - 3*j) : 2'd3;
         exp_q.push_back(e);
      end
      i = 0;
      do begin
         k      = (n - i > lanes) ? lanes : n - i;
         b.data = {$urandom(), $urandom(), $urandom(), $urandom()};
         for (int l = 0; l < k; l++) b.data[l*32 +: 32] = w[i+l];
         b.last = (i + k == n);
         b.nl   = b.last ? k : $urandom_range(0, lanes);
         beat_q.push_back(b);
         i += k;
      end while (i < n);
   endtask

   task automatic finish_msg(input int n, input string tag);
      int base, cyc;
      base = done_seen - ((exp_q.size() == 0) ? 1 : 0);
      cyc  = 0;
      while (!(exp_q.size() == 0 && done_seen > base) && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_timeout"}, 128'(cyc < 3000), 128'(1));
      @(negedge clk);
      chk({tag, "_done_count"}, 128'(done_seen - base), 128'(1));
      chk({tag, "_idle_valid"}, 128'(m_valid), 128'(0));
      chk({tag, "_len"}, 128'(m_len), 128'(n));
      ce = 0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic run_msg(input int n, input string tag);
      int base;
      base = done_seen;
      send_msg(n);
      ce = 1;
      @(negedge clk);
      done_seen = base;
      finish_msg(n, tag);
   endtask

   task automatic clear_models();
      exp_q.delete();
      beat_q.delete();
      done_pops = pop_cnt;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_valid"}, 128'(m_valid), 128'(0));
      chk({tag, "_getn"},  128'(m_getn),  128'(1));
      chk({tag, "_done"},  128'(m_done),  128'(0));
      chk({tag, "_left"},  128'(m_left),  128'(0));
      chk({tag, "_data"},  128'({m_d0, m_d1, m_d2}), 128'(0));
      chk({tag, "_len"},   128'(m_len),   128'(0));
   endtask

   initial begin
      rst = 1;
      ce  = 0;
      si  = 2'd1;
      repeat (3) @(negedge clk);
      chk_reset_outs("reset");
      rst = 0;
      @(negedge clk);

      // Directed messages, IN_LANES=2, always-ready consumer.
      ack_force = 1;
      ack_val   = 1;
      run_msg(10, "ten_words");
      run_msg(6, "six_words");
      run_msg(0, "empty_msg");

      // Consumer stall with a full buffer, then one cycle with pop and fire together.
      ack_val = 0;
      send_msg(10);
      ce = 1;
      repeat (8) @(negedge clk);
      hold_e = exp_q[0];
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("hold_getn", 128'(m_getn), 128'(1));
         chk("hold_data", 128'({m_d0, m_d1, m_d2}), 128'({hold_e.d0, hold_e.d1, hold_e.d2}));
      end
      ack_val = 1;
      @(negedge clk);
      chk("release_getn", 128'(m_getn), 128'(0));
      chk("release_valid", 128'(m_valid), 128'(1));
      finish_msg(10, "hold_msg");

      // Reset while the tail group waits in FLUSH.
      ack_val = 0;
      send_msg(2);
      ce = 1;
      repeat (6) @(negedge clk);
      chk("flush_state", 128'({m_valid, m_done, m_left}), 128'({1'b1, 1'b1, 2'd2}));
      rst = 1;
      #1;
      chk_reset_outs("rst_flush");
      clear_models();
      ce = 0;
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      ack_val = 1;
      run_msg(7, "after_rst");

      // ce dropped while RUN is stalled.
      ack_val = 0;
      send_msg(10);
      ce = 1;
      repeat (6) @(negedge clk);
      ce = 0;
      #1;
      chk("ce_drop_getn", 128'(m_getn), 128'(1));
      @(posedge clk);
      #1;
      chk_reset_outs("ce_drop");
      clear_models();
      @(negedge clk);
      ack_val = 1;
      run_msg(5, "after_ce");

      // Random source gaps and consumer backpressure over other lane counts.
      gap_en    = 1;
      ack_force = 0;
      si = 2'd0;
      repeat (4) run_msg($urandom_range(1, 40), "rand_l1");
      si = 2'd2;
      repeat (4) run_msg($urandom_range(1, 40), "rand_l3");
      si = 2'd3;
      repeat (4) run_msg($urandom_range(1, 40), "rand_l4");
      run_msg(12, "l4_mult3");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
